regfile_stage: RTL and testbench
================================

# regfile_stage

Operand/result storage stage of the multi-cycle simple CPU datapath, directly downstream of the control FSM. It holds the four general-purpose registers (k0-k3), the OpA/OpB operand latches, the ALUOut register and the N/Z flag register. All of these are updated only when the FSM asserts the matching control strobe. It returns N and Z to the FSM for branch resolution.

## Interface
- DATA_W, 8, datapath width in bits
- NREG, 4, number of general registers; index width is 2
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ir  in  8  instruction register contents; ir[7:6] = R1 field, ir[5:4] = R2 field
- mdr  in  DATA_W  memory data register contents
- alu_result  in  DATA_W  combinational ALU output
- OpABLoad  in  1  load both operand latches
- OpASel  in  1  force R1 = k1 for read A and for the write index
- RFWrite  in  1  write the register file
- RegIn  in  1  write-data select: 1 = mdr, 0 = alu_out
- ALUOutWrite  in  1  load alu_out from alu_result
- FlagWrite  in  1  load N/Z from alu_result
- opa  out  DATA_W  operand A latch
- opb  out  DATA_W  operand B latch
- alu_out  out  DATA_W  ALUOut register
- N  out  1  negative flag register
- Z  out  1  zero flag register
- dbg_sel  in  2  debug read index
- dbg_data  out  DATA_W  combinational read of k[dbg_sel], for board display

## Operation
- ra = OpASel ? 2'd1 : ir[7:6]; rb = ir[5:4]; rw = ra.
- OpABLoad: opa <= k[ra], opb <= k[rb]. There is no write bypass; latches take pre-edge contents.
- RFWrite: k[rw] <= RegIn ? mdr : alu_out. The value used is alu_out as it was before the edge.
- ALUOutWrite: alu_out <= alu_result.
- FlagWrite: N <= alu_result[DATA_W-1]; Z <= (alu_result == 0).
- Strobes are independent, and any combination in one cycle is legal:
  - RFWrite+ALUOutWrite+RegIn=1 (load write-back): k[rw] gets mdr; alu_out gets alu_result.
  - RFWrite+ALUOutWrite+RegIn=0: k[rw] gets the old alu_out.
  - RFWrite+OpABLoad to the same index: the latch gets the old value.
- Control inputs outside a strobe have no effect; a strobe with no meaningful payload still loads.
- Arithmetic is pure storage. Widths are exact DATA_W with no extension.
- Flags hold between FlagWrite strobes, so branch states see the flags of the last arithmetic instruction.

## Timing
- Reset (async assert; deassert is synchronous to the next edge): k0-k3, opa, opb, alu_out = 0; N = 0, Z = 0.
- Every registered output changes only on the rising clock edge where its strobe is high. Latency is one cycle from strobe to visible output.
- dbg_data is combinational. It reflects a register write from the edge onward.
- Reset asserted mid-instruction clears everything immediately; partially written results are lost.
- Flag behaviour by FSM state:
  - c3 states with FlagWrite assert the strobe for exactly one cycle, so N/Z are valid in the following cycle.
  - Branch c3 reads N/Z no earlier than the cycle after the previous instruction's FlagWrite.

## Structure
- Shared package `cpu_pkg`: DATA_W, register index width, ir field positions (R1_HI/R1_LO/R2_HI/R2_LO), and the constant K1_IDX = 1 used by OpASel.
- One natural sub-module is `regfile4`. It holds the 4 x DATA_W array with two async read ports (a, b), a debug read port and one sync write port.
- Latches, ALUOut, flags and index muxing live in regfile_stage.

## Test plan
- Reset then RFWrite=1, RegIn=1, mdr=8'h5A, ir=8'b10_00_0000 -> k2=8'h5A next cycle, dbg_sel=2 reads 8'h5A; all other registers 0.
- Preload k2=8'h03, k3=8'h7C, OpABLoad with ir=8'b10_11_0000 -> opa=8'h03, opb=8'h7C. Same with OpASel=1 -> opa=k1.
- alu_result=8'h80 with ALUOutWrite+FlagWrite -> alu_out=8'h80, N=1, Z=0. Then alu_result=8'h00 with FlagWrite only -> N=0, Z=1, alu_out stays 8'h80.
- alu_out=8'h11, same cycle RFWrite (RegIn=0) + ALUOutWrite with alu_result=8'h22 -> k[rw]=8'h11, alu_out=8'h22.
- k1=8'h40, same edge RFWrite to k1 with mdr=8'h99 and OpABLoad with OpASel=1 -> opa=8'h40, k1=8'h99.
- Mid-sequence async reset pulse between clock edges -> all outputs 0 before the next edge; N=Z=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and instruction field positions
package cpu_pkg;
    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int IDX_W  = 2;
    localparam int R1_HI  = 7;
    localparam int R1_LO  = 6;
    localparam int R2_HI  = 5;
    localparam int R2_LO  = 4;
    localparam logic [IDX_W-1:0] K1_IDX = 2'd1;
endpackage

// File: rtl/regfile_stage_if.sv
// rtl/regfile_stage_if.sv - control FSM to regfile_stage strobe/data bundle
interface regfile_stage_if;
    import cpu_pkg::*;

    logic [7:0]        ir;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] alu_result;
    logic              OpABLoad;
    logic              OpASel;
    logic              RFWrite;
    logic              RegIn;
    logic              ALUOutWrite;
    logic              FlagWrite;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_out;
    logic              N;
    logic              Z;

    modport master (
        output ir, mdr, alu_result, OpABLoad, OpASel, RFWrite, RegIn, ALUOutWrite, FlagWrite,
        input  opa, opb, alu_out, N, Z
    );

    modport slave (
        input  ir, mdr, alu_result, OpABLoad, OpASel, RFWrite, RegIn, ALUOutWrite, FlagWrite,
        output opa, opb, alu_out, N, Z
    );
endinterface

// File: rtl/regfile4.sv
// rtl/regfile4.sv - four-entry register array, two async read ports, debug read, one sync write
module regfile4
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic [IDX_W-1:0]  dbg_idx,
    input  logic              w_en,
    input  logic [IDX_W-1:0]  w_idx,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] k [NREG];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                k[i] <= '0;
            end
        end else if (w_en) begin
            k[w_idx] <= w_data;
        end
    end

    assign a_data   = k[a_idx];
    assign b_data   = k[b_idx];
    assign dbg_data = k[dbg_idx];
endmodule

// File: rtl/regfile_stage.sv
// rtl/regfile_stage.sv - register file, operand latches, ALUOut and N/Z flags of the CPU datapath
module regfile_stage
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    regfile_stage_if.slave    bus,
    input  logic [IDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    logic [IDX_W-1:0]  ra;
    logic [IDX_W-1:0]  rb;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] alu_out_q;
    logic              n_q;
    logic              z_q;
    logic [3:0]        unused_ir_low;

    assign unused_ir_low = bus.ir[3:0];

    // The write index follows read A, so OpASel also redirects the write to k1.
    assign ra     = bus.OpASel ? K1_IDX : bus.ir[R1_HI:R1_LO];
    assign rb     = bus.ir[R2_HI:R2_LO];
    assign w_data = bus.RegIn ? bus.mdr : alu_out_q;

    regfile4 u_regfile4 (
        .clock    (clock),
        .reset    (reset),
        .a_idx    (ra),
        .b_idx    (rb),
        .dbg_idx  (dbg_sel),
        .w_en     (bus.RFWrite),
        .w_idx    (ra),
        .w_data   (w_data),
        .a_data   (a_data),
        .b_data   (b_data),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opa_q     <= '0;
            opb_q     <= '0;
            alu_out_q <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            if (bus.OpABLoad) begin
                opa_q <= a_data;
                opb_q <= b_data;
            end
            if (bus.ALUOutWrite) begin
                alu_out_q <= bus.alu_result;
            end
            if (bus.FlagWrite) begin
                n_q <= bus.alu_result[DATA_W-1];
                z_q <= (bus.alu_result == '0);
            end
        end
    end

    assign bus.opa     = opa_q;
    assign bus.opb     = opb_q;
    assign bus.alu_out = alu_out_q;
    assign bus.N       = n_q;
    assign bus.Z       = z_q;
endmodule

// File: tb/tb_regfile_stage.sv
// tb/tb_regfile_stage.sv - directed self-checking bench for regfile_stage
module tb_regfile_stage;
    logic       clock;
    logic       reset;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    int         checks;
    int         errors;

    regfile_stage_if bus ();

    regfile_stage dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.OpABLoad    = 1'b0;
        bus.OpASel      = 1'b0;
        bus.RFWrite     = 1'b0;
        bus.RegIn       = 1'b0;
        bus.ALUOutWrite = 1'b0;
        bus.FlagWrite   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic write_reg(input logic [1:0] idx, input logic [7:0] val);
        bus.ir      = {idx, 6'b0};
        bus.mdr     = val;
        bus.RegIn   = 1'b1;
        bus.RFWrite = 1'b1;
        tick();
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        dbg_sel = 2'd0;
        bus.ir = 8'h00;
        bus.mdr = 8'h00;
        bus.alu_result = 8'h00;
        idle();
        #12;
        reset = 1'b0;
        #1;

        check("reset_opa", bus.opa, 8'h00);
        check("reset_opb", bus.opb, 8'h00);
        check("reset_alu_out", bus.alu_out, 8'h00);
        check("reset_N", {7'b0, bus.N}, 8'h00);
        check("reset_Z", {7'b0, bus.Z}, 8'h00);

        // mdr write-back into k2
        write_reg(2'd2, 8'h5A);
        check_reg("wb_k2", 2'd2, 8'h5A);
        check_reg("wb_k0", 2'd0, 8'h00);
        check_reg("wb_k1", 2'd1, 8'h00);
        check_reg("wb_k3", 2'd3, 8'h00);

        // operand latches, with and without OpASel
        write_reg(2'd2, 8'h03);
        write_reg(2'd3, 8'h7C);
        write_reg(2'd1, 8'h1E);
        bus.ir = 8'b10_11_0000;
        bus.OpABLoad = 1'b1;
        tick();
        check("opab_opa", bus.opa, 8'h03);
        check("opab_opb", bus.opb, 8'h7C);
        bus.ir = 8'b10_11_0000;
        bus.OpASel = 1'b1;
        bus.OpABLoad = 1'b1;
        tick();
        check("opasel_opa", bus.opa, 8'h1E);
        check("opasel_opb", bus.opb, 8'h7C);

        // ALUOut and flags
        bus.alu_result = 8'h80;
        bus.ALUOutWrite = 1'b1;
        bus.FlagWrite = 1'b1;
        tick();
        check("neg_alu_out", bus.alu_out, 8'h80);
        check("neg_N", {7'b0, bus.N}, 8'h01);
        check("neg_Z", {7'b0, bus.Z}, 8'h00);
        bus.alu_result = 8'h00;
        bus.FlagWrite = 1'b1;
        tick();
        check("zero_N", {7'b0, bus.N}, 8'h00);
        check("zero_Z", {7'b0, bus.Z}, 8'h01);
        check("zero_alu_out_hold", bus.alu_out, 8'h80);
        bus.alu_result = 8'hF5;
        tick();
        check("hold_N", {7'b0, bus.N}, 8'h00);
        check("hold_Z", {7'b0, bus.Z}, 8'h01);
        check("hold_alu_out", bus.alu_out, 8'h80);

        // RFWrite from old alu_out while ALUOut reloads
        bus.alu_result = 8'h11;
        bus.ALUOutWrite = 1'b1;
        tick();
        bus.ir = 8'b11_00_0000;
        bus.alu_result = 8'h22;
        bus.RFWrite = 1'b1;
        bus.RegIn = 1'b0;
        bus.ALUOutWrite = 1'b1;
        tick();
        check_reg("alu_wb_k3", 2'd3, 8'h11);
        check("alu_wb_alu_out", bus.alu_out, 8'h22);

        // load write-back: mdr to k0 while ALUOut takes alu_result
        bus.ir = 8'b00_00_0000;
        bus.mdr = 8'h77;
        bus.alu_result = 8'h33;
        bus.RFWrite = 1'b1;
        bus.RegIn = 1'b1;
        bus.ALUOutWrite = 1'b1;
        tick();
        check_reg("ld_wb_k0", 2'd0, 8'h77);
        check("ld_wb_alu_out", bus.alu_out, 8'h33);

        // same-edge write and latch of k1: latch sees pre-edge value
        write_reg(2'd1, 8'h40);
        bus.ir = 8'b00_10_0000;
        bus.mdr = 8'h99;
        bus.OpASel = 1'b1;
        bus.RFWrite = 1'b1;
        bus.RegIn = 1'b1;
        bus.OpABLoad = 1'b1;
        tick();
        check("nobypass_opa", bus.opa, 8'h40);
        check("nobypass_opb", bus.opb, 8'h03);
        check_reg("nobypass_k1", 2'd1, 8'h99);

        // strobes low: payload changes have no effect
        bus.ir = 8'b01_01_0000;
        bus.mdr = 8'hEE;
        bus.alu_result = 8'hDD;
        tick();
        check_reg("idle_k1", 2'd1, 8'h99);
        check("idle_alu_out", bus.alu_out, 8'h33);

        // async reset between edges
        bus.alu_result = 8'hFF;
        bus.FlagWrite = 1'b1;
        tick();
        check("pre_rst_N", {7'b0, bus.N}, 8'h01);
        #1;
        reset = 1'b1;
        #1;
        check("async_opa", bus.opa, 8'h00);
        check("async_opb", bus.opb, 8'h00);
        check("async_alu_out", bus.alu_out, 8'h00);
        check("async_N", {7'b0, bus.N}, 8'h00);
        check("async_Z", {7'b0, bus.Z}, 8'h00);
        check_reg("async_k0", 2'd0, 8'h00);
        check_reg("async_k1", 2'd1, 8'h00);
        check_reg("async_k2", 2'd2, 8'h00);
        check_reg("async_k3", 2'd3, 8'h00);
        reset = 1'b0;
        tick();
        check("post_rst_alu_out", bus.alu_out, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
